// File: rtl/hs_pkg.sv
// Shared types and default sizes for the four-phase sink buffer.
package hs_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } hs_state_t;

  localparam int HS_WIDTH = 8;
  localparam int HS_DEPTH = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level; both flops clear on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hs_sink_buffer.sv
// Four-phase req/ack sink feeding a valid/ready FIFO of depth entries.
// Define HS_SINK_REQ_SYNC_EN to pass req through a two-flop synchronizer.
import hs_pkg::*;

module hs_sink_buffer #(
  parameter int width = HS_WIDTH,
  parameter int depth = HS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     ack,
  input  logic [width-1:0]         data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [width-1:0]         out_data,
  output logic [$clog2(depth):0]   count,
  output hs_state_t                state
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             req_s;
  logic             push;
  logic             pop;

`ifdef HS_SINK_REQ_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (req_s)
  );
`else
  assign req_s = req;
`endif

  // Output handshake: out_valid/out_ready is a plain valid/ready pair; a token
  // transfers on any edge where both are high, and out_ready means nothing
  // while out_valid is low. The full test uses the pre-edge count, so a pop
  // on the same edge never frees space for a push.
  assign push      = (state == S_IDLE) && req_s && (count != FULL);
  assign pop       = out_valid && out_ready;
  assign ack       = (state == S_ACK);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        S_IDLE:  if (push) state <= S_ACK;
        S_ACK:   if (!req_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_hs_sink_buffer.sv
// Bench for hs_sink_buffer: vector table, latency sequence, and a queue-based
// reference model run under directed and random traffic.
module tb_hs_sink_buffer;
  import hs_pkg::*;

  localparam int W = 8;
  localparam int D = 2;
`ifdef HS_SINK_REQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              ack;
  logic [W-1:0]      data_in;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [$clog2(D):0] count;
  hs_state_t         state;

  hs_sink_buffer #(.width(W), .depth(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO contents as a queue plus the expected ack level.
  logic         chk_en = 1'b0;
  logic         m_ack;
  logic [W-1:0] mq[$];
  logic [1:0]   req_hist;
  logic         m_req_s;
  logic         m_push;
  logic         m_pop;
  int           pops;

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ack", ack, m_ack);
      check("m_count", count, mq.size());
      check("m_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) check("m_data", out_data, mq[0]);
      m_req_s = (SYNC == 0) ? req : req_hist[1];
      req_hist = {req_hist[0], req};
      if (!rst) begin
        mq.delete();
        m_ack = 1'b0;
        req_hist = 2'b00;
      end else begin
        m_push = !m_ack && m_req_s && (mq.size() < D);
        m_pop  = (mq.size() != 0) && out_ready;
        if (m_pop) begin
          void'(mq.pop_front());
          pops++;
        end
        if (m_push) mq.push_back(data_in);
        m_ack = m_ack ? m_req_s : m_push;
      end
    end
  end

  task automatic send_token(input logic [W-1:0] d);
    int t;
    req = 1'b1;
    data_in = d;
    t = 0;
    while (ack !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    check("ack_rise", ack, 1'b1);
    req = 1'b0;
    t = 0;
    while (ack !== 1'b0 && t < 300) begin
      tick();
      t++;
    end
    check("ack_fall", ack, 1'b0);
  endtask

  task automatic model_start();
    rst = 1'b0;
    req = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    mq.delete();
    m_ack = 1'b0;
    req_hist = 2'b00;
    pops = 0;
    chk_en = 1'b1;
  endtask

`ifndef HS_SINK_REQ_SYNC_EN
  typedef struct {
    logic         rst;
    logic         req;
    logic [W-1:0] din;
    logic         rdy;
    logic         e_ack;
    logic         e_vld;
    int           e_cnt;
    logic         chk_d;
    logic [W-1:0] e_dat;
  } vec_t;

  vec_t tbl[19];

  task automatic set_vec(input int i, input int r, input int q, input int d, input int rd,
                         input int a, input int v, input int c, input int cd, input int ed);
    tbl[i].rst   = 1'(r);
    tbl[i].req   = 1'(q);
    tbl[i].din   = W'(d);
    tbl[i].rdy   = 1'(rd);
    tbl[i].e_ack = 1'(a);
    tbl[i].e_vld = 1'(v);
    tbl[i].e_cnt = c;
    tbl[i].chk_d = 1'(cd);
    tbl[i].e_dat = W'(ed);
  endtask
`endif

  logic done;

  initial begin
    rst = 1'b0;
    req = 1'b0;
    data_in = '0;
    out_ready = 1'b0;
    done = 1'b0;
    tick();
    tick();
    check("rst_ack", ack, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_state", state, S_IDLE);
    rst = 1'b1;

`ifndef HS_SINK_REQ_SYNC_EN
    //       i  rst req din  rdy ack vld cnt chk dat
    set_vec( 0, 1, 1, 'hA5, 0,  1,  1,  1,  1, 'hA5);
    set_vec( 1, 1, 0, 'h00, 0,  0,  1,  1,  1, 'hA5);
    set_vec( 2, 1, 0, 'h00, 1,  0,  0,  0,  0, 'h00);
    set_vec( 3, 1, 1, 'h01, 0,  1,  1,  1,  1, 'h01);
    set_vec( 4, 1, 0, 'h01, 0,  0,  1,  1,  1, 'h01);
    set_vec( 5, 1, 1, 'h02, 0,  1,  1,  2,  1, 'h01);
    set_vec( 6, 1, 0, 'h02, 0,  0,  1,  2,  1, 'h01);
    set_vec( 7, 1, 1, 'h03, 0,  0,  1,  2,  1, 'h01);
    set_vec( 8, 1, 1, 'h03, 1,  0,  1,  1,  1, 'h02);
    set_vec( 9, 1, 1, 'h03, 0,  1,  1,  2,  1, 'h02);
    set_vec(10, 1, 0, 'h03, 1,  0,  1,  1,  1, 'h03);
    set_vec(11, 1, 0, 'h03, 1,  0,  0,  0,  0, 'h00);
    set_vec(12, 1, 1, 'h11, 0,  1,  1,  1,  1, 'h11);
    set_vec(13, 1, 0, 'h11, 0,  0,  1,  1,  1, 'h11);
    set_vec(14, 1, 1, 'h22, 1,  1,  1,  1,  1, 'h22);
    set_vec(15, 1, 0, 'h22, 0,  0,  1,  1,  1, 'h22);
    set_vec(16, 1, 1, 'h33, 0,  1,  1,  2,  1, 'h22);
    set_vec(17, 0, 1, 'h33, 0,  0,  0,  0,  0, 'h00);
    set_vec(18, 1, 0, 'h00, 0,  0,  0,  0,  0, 'h00);
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      data_in = tbl[i].din;
      out_ready = tbl[i].rdy;
      tick();
      check($sformatf("v%0d_ack", i), ack, tbl[i].e_ack);
      check($sformatf("v%0d_state", i), state == S_ACK, tbl[i].e_ack);
      check($sformatf("v%0d_valid", i), out_valid, tbl[i].e_vld);
      check($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
      if (tbl[i].chk_d) check($sformatf("v%0d_data", i), out_data, tbl[i].e_dat);
    end
`else
    req = 1'b1;
    data_in = 8'hA5;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("sync_ack_e%0d", e), ack, e == 3);
    end
    check("sync_valid", out_valid, 1'b1);
    check("sync_data", out_data, 8'hA5);
    req = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("sync_fall_e%0d", e), ack, e != 3);
    end
    out_ready = 1'b1;
    tick();
    check("sync_drain", count, 0);
`endif

    // Back-to-back tokens 0..9 with the consumer always ready.
    model_start();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_token(W'(i));
    repeat (4) tick();
    check("wrap_pops", pops, 10);

    // Random traffic with a randomly stalling consumer.
    model_start();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send_token(W'($urandom_range(0, 255)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    out_ready = 1'b1;
    repeat (6) tick();
    check("final_count", count, 0);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
